// File: rtl/cs_pkg.sv
// Shared constants, state encodings and the select bundle for the cs_map chip-select unit.
package cs_pkg;

  // Region nibbles, A[23:20]
  localparam logic [3:0] RGN_IACK = 4'hF;
  localparam logic [3:0] RGN_VIA  = 4'hE;
  localparam logic [3:0] RGN_IWM  = 4'hD;
  localparam logic [3:0] RGN_SCCR = 4'hB;
  localparam logic [3:0] RGN_SCCW = 4'h9;
  localparam logic [3:0] RGN_SCSI = 4'h5;
  localparam logic [3:0] RGN_ROM  = 4'h4;

  // Pages inside the video window that also strobe the sound block
  localparam int SND_PAGE_N = 6;
  localparam logic [SND_PAGE_N-1:0][7:0] SND_PAGES =
    {8'hFD, 8'hFE, 8'hFF, 8'hA1, 8'hA2, 8'hA3};

  typedef enum logic {CYC_IDLE, CYC_ACTIVE} cyc_state_t;
  typedef enum logic {OVL_ON, OVL_OFF} ovl_state_t;

  typedef struct packed {
    logic rom;
    logic rom4x;
    logic ram;
    logic ram0x;
    logic io;
    logic io_real;
    logic io_pw;
    logic ia;
    logic iack;
    logic via;
    logic iwm;
    logic scc;
    logic scsi;
    logic snd_wr;
    logic set_wr;
  } cs_sel_t;

  function automatic logic is_snd_page(input logic [7:0] page);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < SND_PAGE_N; i++) begin
      if (SND_PAGES[i] == page) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cs_map_if.sv
// CPU bus-cycle side and chip-select side of cs_map, bundled as one interface.
interface cs_map_if #(parameter int AW = 24);
  logic [AW-1:8] A;
  logic nWE;
  logic BACT;
  logic QoSEN;
  logic PWDone;

  logic ROMCS, ROMCS4X, RAMCS, RAMCS0X;
  logic IOCS, IORealCS, IOPWCS, IACS, IACKCS;
  logic VIACS, IWMCS, SCCCS, SCSICS, SndCSWR, SetCSWR;
  logic Overlay;
  logic PWFull;

  modport master (
    output A, nWE, BACT, QoSEN, PWDone,
    input  ROMCS, ROMCS4X, RAMCS, RAMCS0X, IOCS, IORealCS, IOPWCS, IACS, IACKCS,
           VIACS, IWMCS, SCCCS, SCSICS, SndCSWR, SetCSWR, Overlay, PWFull
  );

  modport slave (
    input  A, nWE, BACT, QoSEN, PWDone,
    output ROMCS, ROMCS4X, RAMCS, RAMCS0X, IOCS, IORealCS, IOPWCS, IACS, IACKCS,
           VIACS, IWMCS, SCCCS, SCSICS, SndCSWR, SetCSWR, Overlay, PWFull
  );
endinterface

// File: rtl/cs_pw_credit.sv
// Saturating up/down credit counter tracking posted writes still in flight to the I/O bridge.
module cs_pw_credit #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          nRES,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (inc && !dec && count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end else if (dec && !inc && count != '0) begin
        count <= count - CW'(1);
      end
      // Flag follows the count one clock later
      full <= (count == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/cs_map.sv
// Bus-cycle chip-select decoder with boot overlay, posted-write credits and QoS hold.
module cs_map
  import cs_pkg::*;
#(
  parameter int         AW       = 24,
  parameter int         PW_DEPTH = 2,
  parameter int         QOS_HOLD = 8,
  parameter logic [7:0] VID_BASE = 8'h3F
) (
  input logic    CLK,
  input logic    nRES,
  cs_map_if.slave bus
);

  localparam int CW = $clog2(PW_DEPTH + 1);
  localparam int QW = (QOS_HOLD > 0) ? $clog2(QOS_HOLD + 1) : 1;

  cyc_state_t    cyc;
  ovl_state_t    ovl;
  cs_sel_t       sel;
  cs_sel_t       dec;
  logic [QW-1:0] hold;
  logic [CW-1:0] count;
  logic          full;
  logic [3:0]    rgn;
  logic          mapped;
  logic          vw;
  logic          qos;
  logic          post;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec    = '0;
    rgn    = bus.A[23:20];
    mapped = ((bus.A >> 16) == '0);
    vw     = (bus.A[23:16] == VID_BASE) && !bus.nWE;
    qos    = bus.QoSEN || (hold != '0);
    if (mapped) begin
      dec.rom4x   = (rgn == RGN_ROM);
      dec.ram0x   = (bus.A[23:22] == 2'b00);
      dec.rom     = (ovl == OVL_ON) || dec.rom4x;
      dec.ram     = (ovl == OVL_OFF) && dec.ram0x;
      dec.io_real = (rgn >= RGN_SCSI);
      dec.ia      = (rgn == RGN_IACK);
      dec.iack    = (rgn == RGN_IACK);
      dec.via     = (rgn == RGN_VIA);
      dec.iwm     = (rgn == RGN_IWM);
      dec.scc     = (rgn == RGN_SCCR) || (rgn == RGN_SCCW);
      dec.scsi    = (rgn == RGN_SCSI);
      dec.snd_wr  = vw && is_snd_page(bus.A[15:8]);
      dec.set_wr  = (rgn == RGN_IACK) && !bus.A[19] && !bus.nWE;
      dec.io      = dec.io_real || vw || qos;
      // A full credit pool sends the video write down the non-posted IOCS path
      dec.io_pw   = vw && !qos && (count < CW'(PW_DEPTH));
    end
  end

  assign post = (cyc == CYC_IDLE) && bus.BACT && dec.io_pw;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      cyc  <= CYC_IDLE;
      ovl  <= OVL_ON;
      sel  <= '0;
      hold <= '0;
    end else begin
      if (bus.QoSEN) begin
        hold <= QW'(QOS_HOLD);
      end else if (hold != '0) begin
        hold <= hold - QW'(1);
      end
      case (cyc)
        CYC_IDLE: begin
          if (bus.BACT) begin
            sel <= dec;
            cyc <= CYC_ACTIVE;
          end
        end
        CYC_ACTIVE: begin
          // The ROM4X cycle itself keeps ROMCS; the overlay drops for the next one
          if (sel.rom4x) ovl <= OVL_OFF;
          if (!bus.BACT) begin
            sel <= '0;
            cyc <= CYC_IDLE;
          end
        end
      endcase
    end
  end

  cs_pw_credit #(.DEPTH(PW_DEPTH)) u_credit (
    .CLK   (CLK),
    .nRES  (nRES),
    .inc   (post),
    .dec   (bus.PWDone),
    .count (count),
    .full  (full)
  );

  assign bus.ROMCS    = sel.rom;
  assign bus.ROMCS4X  = sel.rom4x;
  assign bus.RAMCS    = sel.ram;
  assign bus.RAMCS0X  = sel.ram0x;
  assign bus.IOCS     = sel.io;
  assign bus.IORealCS = sel.io_real;
  assign bus.IOPWCS   = sel.io_pw;
  assign bus.IACS     = sel.ia;
  assign bus.IACKCS   = sel.iack;
  assign bus.VIACS    = sel.via;
  assign bus.IWMCS    = sel.iwm;
  assign bus.SCCCS    = sel.scc;
  assign bus.SCSICS   = sel.scsi;
  assign bus.SndCSWR  = sel.snd_wr;
  assign bus.SetCSWR  = sel.set_wr;
  assign bus.Overlay  = (ovl == OVL_ON);
  assign bus.PWFull   = full;

endmodule
